// File: rtl/mdio_pkg.sv
// Shared types, frame constants and the frame builder for the Clause-22 MDIO master.
// Read support is compiled in only when MDIO_READ_EN is defined.
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        HDR  = 3'd2,
        TA   = 3'd3,
        DATA = 3'd4,
        DONE = 3'd5
    } mdio_state_e;

    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;

    localparam int PRE_LEN   = 32;
    localparam int FRAME_LEN = 64;

    // Bit-counter values of the last bit in each frame phase
    localparam logic [5:0] PRE_LAST  = 6'd31;
    localparam logic [5:0] HDR_LAST  = 6'd45;
    localparam logic [5:0] TA_LAST   = 6'd47;
    localparam logic [5:0] DATA_LAST = 6'd63;

    // Reads carry all-ones in TA/DATA so that mdio_o idles high while released
    function automatic logic [FRAME_LEN-1:0] build_frame(
        input logic        is_wr,
        input logic [4:0]  phy_add,
        input logic [4:0]  reg_add,
        input logic [15:0] wr_data
    );
        logic [1:0]  op;
        logic [1:0]  ta;
        logic [15:0] data;
        if (is_wr) begin
            op   = MDIO_OP_WR;
            ta   = 2'b10;
            data = wr_data;
        end else begin
            op   = MDIO_OP_RD;
            ta   = 2'b11;
            data = 16'hFFFF;
        end
        return {{PRE_LEN{1'b1}}, MDIO_ST, op, phy_add, reg_add, ta, data};
    endfunction

endpackage

// File: rtl/mdio_clk_gen.sv
// MDC generator: CLK_DIV clk cycles per half-period, with one-cycle rise/fall strobes
// that coincide with the clk cycle in which mdc changes.
module mdio_clk_gen #(
    parameter int CLK_DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mdc,
    output logic mdc_rise,
    output logic mdc_fall
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0] cnt_r;
    logic       mdc_r;
    logic       wrap_s;

    assign wrap_s   = en && (cnt_r == DIV_LAST);
    assign mdc_rise = wrap_s && !mdc_r;
    assign mdc_fall = wrap_s && mdc_r;
    assign mdc      = mdc_r;

    // Half-period counter; held at zero with mdc low whenever disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
            mdc_r <= 1'b0;
        end else if (!en) begin
            cnt_r <= 8'd0;
            mdc_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r <= 8'd0;
            mdc_r <= ~mdc_r;
        end else begin
            cnt_r <= cnt_r + 8'd1;
            mdc_r <= mdc_r;
        end
    end

endmodule

// File: rtl/mdio_master.sv
// Clause-22 MDIO management master: one 64-bit frame per accepted request.
// Define MDIO_READ_EN to build the read path; otherwise only writes are accepted.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLK_DIV = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  phy_add_i,
    input  logic [4:0]  reg_add_i,
    input  logic [15:0] wr_data_i,
    input  logic        wren,
    input  logic        rden,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    mdio_state_e          state_r, state_s;
    logic [FRAME_LEN-1:0] frame_r, frame_s;
    logic [5:0]           bit_cnt_r, bit_cnt_s;
    logic                 is_wr_r, is_wr_s;
    logic                 busy_r, busy_s;
    logic                 mdio_o_r, mdio_o_s;
    logic                 mdio_oe_r, mdio_oe_s;
    logic                 rden_s;
    logic                 accept_s;
    logic                 clk_en_s;
    logic                 mdc_rise_s;
    logic                 mdc_fall_s;

`ifdef MDIO_READ_EN
    assign rden_s = rden;
`else
    assign rden_s = 1'b0;
`endif

    assign accept_s = (state_r == IDLE) && !busy_r && (wren || rden_s);
    // MDC stops in DONE so the next frame always begins from a fresh low phase
    assign clk_en_s = busy_r && (state_r != DONE);

    mdio_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (clk_en_s),
        .mdc      (mdc),
        .mdc_rise (mdc_rise_s),
        .mdc_fall (mdc_fall_s)
    );

    // State register and registered frame outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            frame_r   <= '1;
            bit_cnt_r <= 6'd0;
            is_wr_r   <= 1'b1;
            busy_r    <= 1'b0;
            mdio_o_r  <= 1'b1;
            mdio_oe_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            frame_r   <= frame_s;
            bit_cnt_r <= bit_cnt_s;
            is_wr_r   <= is_wr_s;
            busy_r    <= busy_s;
            mdio_o_r  <= mdio_o_s;
            mdio_oe_r <= mdio_oe_s;
        end
    end

    // Next-state logic: phases advance on the MDC falling edge that ends their last bit
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: if (accept_s) state_s = PRE; else state_s = IDLE;
            PRE:  if (mdc_fall_s && bit_cnt_r == PRE_LAST)  state_s = HDR;  else state_s = PRE;
            HDR:  if (mdc_fall_s && bit_cnt_r == HDR_LAST)  state_s = TA;   else state_s = HDR;
            TA:   if (mdc_fall_s && bit_cnt_r == TA_LAST)   state_s = DATA; else state_s = TA;
            DATA: if (mdc_fall_s && bit_cnt_r == DATA_LAST) state_s = DONE; else state_s = DATA;
            DONE: state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Output logic: frame load/shift and next values of the MDIO pins
    always_comb begin
        frame_s   = frame_r;
        bit_cnt_s = bit_cnt_r;
        is_wr_s   = is_wr_r;
        busy_s    = (state_s != IDLE);
        mdio_o_s  = 1'b1;
        mdio_oe_s = 1'b0;
        if (accept_s) begin
            frame_s   = build_frame(wren, phy_add_i, reg_add_i, wr_data_i);
            bit_cnt_s = 6'd0;
            is_wr_s   = wren;
        end else if (mdc_fall_s) begin
            frame_s   = {frame_r[FRAME_LEN-2:0], 1'b1};
            bit_cnt_s = bit_cnt_r + 6'd1;
        end else begin
            frame_s   = frame_r;
            bit_cnt_s = bit_cnt_r;
        end
        case (state_s)
            PRE, HDR: begin
                mdio_oe_s = 1'b1;
                mdio_o_s  = frame_s[FRAME_LEN-1];
            end
            TA, DATA: begin
                if (is_wr_s) begin
                    mdio_oe_s = 1'b1;
                    mdio_o_s  = frame_s[FRAME_LEN-1];
                end else begin
                    mdio_oe_s = 1'b0;
                    mdio_o_s  = 1'b1;
                end
            end
            default: begin
                mdio_oe_s = 1'b0;
                mdio_o_s  = 1'b1;
            end
        endcase
    end

    assign busy    = busy_r;
    assign mdio_o  = mdio_o_r;
    assign mdio_oe = mdio_oe_r;

`ifdef MDIO_READ_EN
    logic [15:0] rx_r;
    logic [15:0] rd_data_r;
    logic        rd_valid_r;
    logic        rd_done_s;

    // A read finishes on the edge that enters DONE, so rd_valid lines up with the last busy cycle
    assign rd_done_s = (state_s == DONE) && !is_wr_r;

    // Read shift register and returned data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_r       <= 16'h0000;
            rd_data_r  <= 16'h0000;
            rd_valid_r <= 1'b0;
        end else begin
            if (mdc_rise_s && state_r == DATA && !is_wr_r) begin
                rx_r <= {rx_r[14:0], mdio_i};
            end else begin
                rx_r <= rx_r;
            end
            if (rd_done_s) begin
                rd_data_r <= rx_r;
            end else begin
                rd_data_r <= rd_data_r;
            end
            rd_valid_r <= rd_done_s;
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
`else
    logic unused_s;
    assign unused_s = mdio_i ^ rden ^ mdc_rise_s;
    assign rd_data  = 16'h0000;
    assign rd_valid = 1'b0;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// Directed self-checking bench for mdio_master with CLK_DIV=2 (MDC period of 4 clk).
// The read-path steps run only when MDIO_READ_EN is defined.
module tb_mdio_master;

    localparam int DIV       = 2;
    localparam int BUSY_CYCS = 128 * DIV + 1;
    localparam logic [63:0] OE_WR = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] OE_RD = 64'hFFFF_FFFF_FFFC_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  phy_add_i;
    logic [4:0]  reg_add_i;
    logic [15:0] wr_data_i;
    logic        wren;
    logic        rden;
    logic        busy;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    int n_checks = 0;
    int n_errors = 0;

    mdio_master #(
        .CLK_DIV (DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .phy_add_i (phy_add_i),
        .reg_add_i (reg_add_i),
        .wr_data_i (wr_data_i),
        .wren      (wren),
        .rden      (rden),
        .busy      (busy),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .mdc       (mdc),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .mdio_i    (mdio_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, follows the frame to its end, playing the PHY on reads.
    task automatic do_frame(input logic wr, input logic rd, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [15:0] wd, input logic [15:0] ret,
                            input logic [63:0] exp_bits, input logic [63:0] exp_oe,
                            input int exp_rv, input int poke_at, input string tag);
        logic [63:0] bits = '0;
        logic [63:0] oes  = '0;
        logic        prev_mdc = 1'b0;
        int rises = 0;
        int bcyc  = 0;
        int rv_cnt = 0;
        int rv_idx = -1;
        phy_add_i = phy; reg_add_i = ra; wr_data_i = wd; wren = wr; rden = rd;
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0;
        phy_add_i = ~phy; reg_add_i = ~ra; wr_data_i = ~wd;
        check({tag, "_start"}, {60'd0, busy, mdio_oe, mdio_o, mdc}, 64'hE);
        for (int c = 0; c < 600 && busy; c++) begin
            bcyc++;
            if (rd_valid) begin
                rv_cnt++;
                rv_idx = bcyc;
            end
            if (mdc && !prev_mdc) begin
                bits = {bits[62:0], mdio_o};
                oes  = {oes[62:0], mdio_oe};
                rises++;
                if (rises >= 48 && rises < 64) mdio_i = ret[63-rises];
            end
            prev_mdc = mdc;
            wren = (c == poke_at);
            @(posedge clk); #1;
        end
        wren = 1'b0;
        if (rd_valid) rv_cnt++;
        check({tag, "_busy_cycles"}, 64'(bcyc), 64'(BUSY_CYCS));
        check({tag, "_rises"}, 64'(rises), 64'd64);
        check({tag, "_bits"}, bits & exp_oe, exp_bits & exp_oe);
        check({tag, "_oe"}, oes, exp_oe);
        check({tag, "_rd_valid_cnt"}, 64'(rv_cnt), 64'(exp_rv));
        if (exp_rv == 1) begin
            check({tag, "_rd_valid_pos"}, 64'(rv_idx), 64'(bcyc));
            check({tag, "_rd_data"}, 64'(rd_data), 64'(ret));
        end
    endtask

    // Watches an idle stretch: busy must stay low and rd_valid must never fire.
    task automatic idle_watch(input int cycs, input string tag);
        int nb = 0;
        int nv = 0;
        for (int c = 0; c < cycs; c++) begin
            @(posedge clk); #1;
            if (busy) nb++;
            if (rd_valid) nv++;
        end
        check({tag, "_idle_busy"}, 64'(nb), 64'd0);
        check({tag, "_idle_rd_valid"}, 64'(nv), 64'd0);
    endtask

    initial begin
        int rises;
        logic prev_mdc;
        rst_n = 1'b0; phy_add_i = 5'd0; reg_add_i = 5'd0; wr_data_i = 16'h0000;
        wren = 1'b0; rden = 1'b0; mdio_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pins", {59'd0, busy, rd_valid, mdc, mdio_o, mdio_oe}, 64'h2);
        check("reset_rd_data", 64'(rd_data), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_frame(1'b1, 1'b0, 5'h01, 5'h00, 16'h3100, 16'h0000,
                 64'hFFFF_FFFF_5082_3100, OE_WR, 0, -1, "wr1");

`ifdef MDIO_READ_EN
        do_frame(1'b0, 1'b1, 5'h02, 5'h02, 16'h0000, 16'h0283,
                 64'hFFFF_FFFF_6108_0000, OE_RD, 1, -1, "rd1");
`else
        rden = 1'b1;
        @(posedge clk); #1;
        rden = 1'b0;
        check("rden_ignored", {63'd0, busy}, 64'h0);
        idle_watch(20, "rden_ignored");
`endif

        do_frame(1'b1, 1'b1, 5'h1F, 5'h1F, 16'hA5A5, 16'h0000,
                 64'hFFFF_FFFF_5FFE_A5A5, OE_WR, 0, 50, "both_poke");
        idle_watch(20, "after_poke");
`ifdef MDIO_READ_EN
        check("rd_data_kept", 64'(rd_data), 64'h0283);
`else
        check("rd_data_tied", 64'(rd_data), 64'h0);
`endif

        do_frame(1'b1, 1'b0, 5'h05, 5'h11, 16'h0001, 16'h0000,
                 64'hFFFF_FFFF_52C6_0001, OE_WR, 0, -1, "b2b_a");
        do_frame(1'b1, 1'b0, 5'h01, 5'h00, 16'h3100, 16'h0000,
                 64'hFFFF_FFFF_5082_3100, OE_WR, 0, -1, "b2b_b");

        phy_add_i = 5'h02; reg_add_i = 5'h02; wr_data_i = 16'h1234;
`ifdef MDIO_READ_EN
        rden = 1'b1;
`else
        wren = 1'b1;
`endif
        @(posedge clk); #1;
        wren = 1'b0; rden = 1'b0;
        rises = 0;
        prev_mdc = 1'b0;
        for (int c = 0; c < 400 && rises < 40; c++) begin
            if (mdc && !prev_mdc) rises++;
            prev_mdc = mdc;
            if (rises < 40) begin
                @(posedge clk); #1;
            end
        end
        check("abort_reached_bit40", 64'(rises), 64'd40);
        rst_n = 1'b0;
        #1;
        check("abort_async", {60'd0, busy, mdc, mdio_oe, rd_valid}, 64'h0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("abort_held", {59'd0, busy, mdc, mdio_oe, mdio_o, rd_valid}, 64'h2);
        end
        rst_n = 1'b1;
        idle_watch(10, "abort_release");
        check("abort_mdc_oe", {62'd0, mdc, mdio_oe}, 64'h0);

        do_frame(1'b1, 1'b0, 5'h01, 5'h00, 16'h3100, 16'h0000,
                 64'hFFFF_FFFF_5082_3100, OE_WR, 0, -1, "fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
